// File: rtl/frame_defs_pkg.sv
// Frame geometry and FAS bytes shared by the sender map path (sequencer,
// frame_controller) and the deframer.
package frame_defs_pkg;

   localparam int ROWS    = 4;
   localparam int COLS    = 1041;
   localparam int OH_COLS = 16;

   localparam int ROW_W = 2;
   localparam int COL_W = 11;

   // Sized forms of the column boundaries, for width-clean comparisons.
   localparam logic [COL_W-1:0] PAD_COL   = COL_W'(COLS - 1);
   localparam logic [COL_W-1:0] OH_LAST   = COL_W'(OH_COLS - 1);
   localparam logic [COL_W-1:0] PYLD_LAST = COL_W'(COLS - 2);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);

   localparam logic [7:0] FAS_OA1   = 8'hF6;
   localparam logic [7:0] FAS_OA2   = 8'h28;
   localparam logic [7:0] FILL_BYTE = 8'h00;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } seq_state_t;

endpackage

// File: rtl/frame_pos_counter.sv
// Row/column position counter for the 4 x 1041 frame; steps once per clock
// while i_step is high and returns to row 0, column 0 otherwise.
module frame_pos_counter
   import frame_defs_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_step,
   output logic [ROW_W-1:0] o_row,
   output logic [COL_W-1:0] o_col,
   output logic             o_last_col,
   output logic             o_last_row
);

   assign o_last_col = (o_col == PAD_COL);
   assign o_last_row = (o_row == LAST_ROW);

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block evaluation order.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         o_row <= '0;
         o_col <= '0;
      end else if (!i_step) begin
         o_row <= '0;
         o_col <= '0;
      end else if (o_last_col) begin
         o_col <= '0;
         o_row <= o_last_row ? '0 : o_row + 1'b1;
      end else begin
         o_col <= o_col + 1'b1;
      end
   end

endmodule

// File: rtl/frame_sequencer.sv
// Drives frame_controller: presents row/column, overhead enable and payload
// bytes pulled from the client, filling on underrun; ARQ mode per frame.
module frame_sequencer
   import frame_defs_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_arq_en,
   input  logic             i_clr_stats,
   input  logic [7:0]       i_client_data,
   input  logic             i_client_valid,
   output logic             o_client_ready,
   output logic [ROW_W-1:0] o_row_cnt,
   output logic [COL_W-1:0] o_col_cnt,
   output logic             o_enable,
   output logic [7:0]       o_pyld_data,
   output logic             o_pyld_data_valid,
   output logic             o_arq_en,
   output logic             o_sof,
   output logic [7:0]       o_frame_cnt,
   output logic             o_underrun,
   output logic [15:0]      o_underrun_cnt
);

   // Reset asserts asynchronously but releases two clocks after i_rst rises.
   logic [1:0] rst_sync;
   logic       rst_int_n;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) rst_sync <= '0;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_int_n = rst_sync[1];

   seq_state_t state, state_nxt;
   logic       step, last_col, last_row, frame_last;
   logic       sof_nxt, enable_nxt, underrun_nxt;

   frame_pos_counter u_pos (
      .i_clk      (i_clk),
      .i_rst      (rst_int_n),
      .i_step     (step),
      .o_row      (o_row_cnt),
      .o_col      (o_col_cnt),
      .o_last_col (last_col),
      .o_last_row (last_row)
   );

   assign frame_last = last_row & last_col;

   always_ff @(posedge i_clk or negedge rst_int_n) begin
      if (!rst_int_n) state <= ST_IDLE;
      else            state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      case (state)
         ST_IDLE: if (i_start) state_nxt = ST_RUN;
         ST_RUN: begin
            step = 1'b1;
            if (frame_last && !i_start) begin
               state_nxt = ST_IDLE;
               step      = 1'b0;
            end
         end
      endcase
   end

   // Decisions below look one position ahead, since outputs register on the
   // same edge that advances the counter.
   assign sof_nxt        = (state_nxt == ST_RUN) && ((state == ST_IDLE) || frame_last);
   assign enable_nxt     = (state_nxt == ST_RUN) && ((o_col_cnt == PAD_COL) || (o_col_cnt < OH_LAST));
   assign o_client_ready = (state == ST_RUN) && (o_col_cnt >= OH_LAST) && (o_col_cnt < PYLD_LAST);
   assign underrun_nxt   = o_client_ready & ~i_client_valid;

   always_ff @(posedge i_clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         o_enable          <= 1'b0;
         o_sof             <= 1'b0;
         o_pyld_data       <= '0;
         o_pyld_data_valid <= 1'b0;
         o_underrun        <= 1'b0;
         o_arq_en          <= 1'b0;
         o_frame_cnt       <= '0;
         o_underrun_cnt    <= '0;
      end else begin
         o_enable          <= enable_nxt;
         o_sof             <= sof_nxt;
         o_pyld_data_valid <= o_client_ready;
         o_underrun        <= underrun_nxt;

         if (!o_client_ready)     o_pyld_data <= '0;
         else if (i_client_valid) o_pyld_data <= i_client_data;
         else                     o_pyld_data <= FILL_BYTE;

         if (sof_nxt) begin
            o_arq_en    <= i_arq_en;
            o_frame_cnt <= o_frame_cnt + 1'b1;
         end

         if (i_clr_stats)
            o_underrun_cnt <= '0;
         else if (underrun_nxt && (o_underrun_cnt != 16'hFFFF))
            o_underrun_cnt <= o_underrun_cnt + 1'b1;
      end
   end

endmodule
